// File: rtl/dense_25d_stream.sv
// Streaming 2.5D dense convolution: per-channel line buffers, K_SIZE x K_SIZE x Z_DEPTH window,
// registered adder trees. Optional per-tree output bias under `define DENSE_25D_BIAS_EN.

module dense_25d_add_tree #(
  parameter int unsigned N = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [32*N-1:0] i_leaves,
  output logic [31:0]     o_sum
);
  localparam int unsigned LVLS = $clog2(N);

  if (LVLS == 0) begin : g_pass
    assign o_sum = i_leaves[31:0];
  end else begin : g_tree
    logic [31:0] w_in  [LVLS][2*N];
    logic [31:0] r_lvl [LVLS][2*N];

    // Level inputs are zero-padded so an odd leaf pairs with zero and simply passes through.
    always_comb begin
      for (int l = 0; l < int'(LVLS); l++) begin
        for (int j = 0; j < int'(2*N); j++) begin
          if (l == 0) w_in[l][j] = (j < int'(N)) ? i_leaves[32*(j % int'(N)) +: 32] : 32'd0;
          else        w_in[l][j] = r_lvl[(l + int'(LVLS) - 1) % int'(LVLS)][j];
        end
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int l = 0; l < int'(LVLS); l++)
          for (int i = 0; i < int'(2*N); i++) r_lvl[l][i] <= '0;
      end else begin
        for (int l = 0; l < int'(LVLS); l++)
          for (int i = 0; i < int'(2*N); i++)
            r_lvl[l][i] <= (i < int'(N)) ? w_in[l][(2*i) % int'(2*N)] + w_in[l][(2*i+1) % int'(2*N)]
                                         : 32'd0;
      end
    end

    assign o_sum = r_lvl[LVLS-1][0];
  end
endmodule

module dense_25d_stream #(
  parameter int unsigned NUM_TREES = 2,
  parameter int unsigned Z_DEPTH   = 4,
  parameter int unsigned K_SIZE    = 4,
  parameter int unsigned ROW_LEN   = 16,
  parameter int unsigned STRIDE    = 1
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [8*Z_DEPTH-1:0]                      pixel_vector_in,
  input  logic                                      pixel_valid_in,
  input  logic                                      pixel_sof_in,
  input  logic [8*NUM_TREES*K_SIZE*K_SIZE*Z_DEPTH-1:0] kernel,
`ifdef DENSE_25D_BIAS_EN
  input  logic [32*NUM_TREES-1:0]                   bias,
`endif
  output logic [32*NUM_TREES-1:0]                   pixel_vector_out,
  output logic                                      pixel_valid_out
);
  localparam int unsigned KK      = K_SIZE * K_SIZE;
  localparam int unsigned BUF_LEN = (K_SIZE - 1) * ROW_LEN + K_SIZE;
  localparam int unsigned LAT     = 2 + $clog2(KK) + $clog2(Z_DEPTH);
  localparam int unsigned CW      = $clog2(ROW_LEN);
  localparam int unsigned RW      = $clog2(K_SIZE);
  localparam int unsigned PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  function automatic int unsigned tap(input int unsigned p);
    return (K_SIZE - 1 - p / K_SIZE) * ROW_LEN + (K_SIZE - 1 - p % K_SIZE);
  endfunction

  function automatic logic [31:0] mul_px(input logic [7:0] px, input logic [7:0] w);
    logic signed [16:0] m;
    m = $signed({1'b0, px}) * $signed(w);
    return 32'(m);
  endfunction

  function automatic logic [PW-1:0] ph_inc(input logic [PW-1:0] ph);
    return (ph == PW'(STRIDE - 1)) ? '0 : ph + PW'(1);
  endfunction

  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic [PW-1:0] r_hph, w_hph, r_vph, w_vph;
  logic          w_col_ok, w_row_ok, w_win_ok, w_wrap;
  logic [7:0]    r_lb [Z_DEPTH][BUF_LEN];
  logic [LAT-1:0] r_vld;
  logic [32*KK-1:0] r_prod [Z_DEPTH*NUM_TREES];
  logic [31:0]   w_sp [Z_DEPTH*NUM_TREES];
  logic [32*Z_DEPTH-1:0] w_ch_in [NUM_TREES];
  logic [31:0]   w_ch [NUM_TREES];

  // Coordinates of the pixel being accepted; sof overrides everything, including a row wrap.
  always_comb begin
    w_col    = pixel_sof_in ? '0 : r_col;
    w_row    = pixel_sof_in ? '0 : r_row;
    w_hph    = pixel_sof_in ? '0 : r_hph;
    w_vph    = pixel_sof_in ? '0 : r_vph;
    w_col_ok = w_col >= CW'(K_SIZE - 1);
    w_row_ok = w_row >= RW'(K_SIZE - 1);
    w_wrap   = w_col == CW'(ROW_LEN - 1);
    w_win_ok = w_col_ok && w_row_ok && (w_hph == '0) && (w_vph == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
      r_hph <= '0;
      r_vph <= '0;
    end else if (pixel_valid_in) begin
      r_col <= w_wrap ? '0 : w_col + CW'(1);
      if (w_wrap) begin
        r_hph <= '0;
        r_row <= w_row_ok ? w_row : w_row + RW'(1);
        r_vph <= w_row_ok ? ph_inc(w_vph) : w_vph;
      end else begin
        r_row <= w_row;
        r_vph <= w_vph;
        r_hph <= w_col_ok ? ph_inc(w_hph) : w_hph;
      end
    end
  end

  // Line buffers (index 0 = newest) and the window-valid pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int z = 0; z < int'(Z_DEPTH); z++)
        for (int d = 0; d < int'(BUF_LEN); d++) r_lb[z][d] <= '0;
      r_vld <= '0;
    end else begin
      if (pixel_valid_in) begin
        for (int z = 0; z < int'(Z_DEPTH); z++) begin
          r_lb[z][0] <= pixel_vector_in[8*z +: 8];
          for (int d = 1; d < int'(BUF_LEN); d++) r_lb[z][d] <= r_lb[z][d-1];
        end
      end
      r_vld <= {r_vld[LAT-2:0], pixel_valid_in && w_win_ok};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < int'(Z_DEPTH*NUM_TREES); g++) r_prod[g] <= '0;
    end else begin
      for (int z = 0; z < int'(Z_DEPTH); z++)
        for (int t = 0; t < int'(NUM_TREES); t++)
          for (int p = 0; p < int'(KK); p++)
            r_prod[z*int'(NUM_TREES)+t][32*p +: 32] <=
              mul_px(r_lb[z][tap(p)], kernel[8*((z*int'(NUM_TREES)+t)*int'(KK)+p) +: 8]);
    end
  end

  for (genvar g = 0; g < int'(Z_DEPTH*NUM_TREES); g++) begin : g_sp
    dense_25d_add_tree #(.N(KK)) u_tree (
      .clock(clock), .reset(reset), .i_leaves(r_prod[g]), .o_sum(w_sp[g])
    );
  end

  for (genvar t = 0; t < int'(NUM_TREES); t++) begin : g_ch
    for (genvar z = 0; z < int'(Z_DEPTH); z++) begin : g_z
      assign w_ch_in[t][32*z +: 32] = w_sp[z*int'(NUM_TREES)+t];
    end
    dense_25d_add_tree #(.N(Z_DEPTH)) u_tree (
      .clock(clock), .reset(reset), .i_leaves(w_ch_in[t]), .o_sum(w_ch[t])
    );
  end

  // Output register holds its value through bubbles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pixel_vector_out <= '0;
      pixel_valid_out  <= 1'b0;
    end else begin
      pixel_valid_out <= r_vld[LAT-1];
      if (r_vld[LAT-1]) begin
        for (int t = 0; t < int'(NUM_TREES); t++) begin
`ifdef DENSE_25D_BIAS_EN
          pixel_vector_out[32*t +: 32] <= w_ch[t] + bias[32*t +: 32];
`else
          pixel_vector_out[32*t +: 32] <= w_ch[t];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_dense_25d_stream.sv
// Bench for dense_25d_stream: stride-1 and stride-2 instances against a coordinate/history model.
`timescale 1ns/1ps
module tb_dense_25d_stream;
  localparam int T = 2, Z = 2, K = 2, RL = 4, KK = 4, LAT = 5, NE = 8192;
`ifdef DENSE_25D_BIAS_EN
  localparam logic [63:0] BIAS = {32'hFFFFFFFB, 32'd100};
`else
  localparam logic [63:0] BIAS = 64'd0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] pixel_vector_in;
  logic        pixel_valid_in, pixel_sof_in;
  logic [8*T*KK*Z-1:0] kernel;
  logic [63:0] out0, out1;
  logic        vld0, vld1;

  dense_25d_stream #(.NUM_TREES(T), .Z_DEPTH(Z), .K_SIZE(K), .ROW_LEN(RL), .STRIDE(1)) u_s1 (
    .clock(clock), .reset(reset), .pixel_vector_in(pixel_vector_in),
    .pixel_valid_in(pixel_valid_in), .pixel_sof_in(pixel_sof_in), .kernel(kernel),
`ifdef DENSE_25D_BIAS_EN
    .bias(BIAS),
`endif
    .pixel_vector_out(out0), .pixel_valid_out(vld0)
  );

  dense_25d_stream #(.NUM_TREES(T), .Z_DEPTH(Z), .K_SIZE(K), .ROW_LEN(RL), .STRIDE(2)) u_s2 (
    .clock(clock), .reset(reset), .pixel_vector_in(pixel_vector_in),
    .pixel_valid_in(pixel_valid_in), .pixel_sof_in(pixel_sof_in), .kernel(kernel),
`ifdef DENSE_25D_BIAS_EN
    .bias(BIAS),
`endif
    .pixel_vector_out(out1), .pixel_valid_out(vld1)
  );

  logic [15:0] hist [NE];
  bit          exp_v [2][NE];
  logic [63:0] exp_d [2][NE];
  logic [63:0] last_d [2];
  int edge_n = 0, n_acc = 0, fpos = 0;
  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] with_bias(input logic [31:0] t1, input logic [31:0] t0);
    logic [63:0] b;
    b = BIAS;
    return {t1 + b[63:32], t0 + b[31:0]};
  endfunction

  // Dot product over the window ending at the newest accepted pixel.
  function automatic logic [63:0] win_sum();
    logic [31:0] acc [2];
    logic [7:0]  px, w;
    for (int t = 0; t < T; t++) begin
      acc[t] = 32'd0;
      for (int z = 0; z < Z; z++)
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) begin
            px = hist[n_acc - ((K-1-r)*RL + (K-1-c))][8*z +: 8];
            w  = kernel[8*((z*T+t)*KK + r*K + c) +: 8];
            acc[t] = acc[t] + 32'(int'(px) * int'($signed(w)));
          end
    end
    return with_bias(acc[1], acc[0]);
  endfunction

  task automatic model_accept(input logic s, input logic [15:0] px);
    int col, rowi, st;
    if (s) fpos = 0;
    hist[n_acc] = px;
    col  = fpos % RL;
    rowi = fpos / RL;
    for (int i = 0; i < 2; i++) begin
      st = i + 1;
      if (col >= K-1 && rowi >= K-1 && (col-(K-1)) % st == 0 && (rowi-(K-1)) % st == 0) begin
        exp_v[i][edge_n+LAT] = 1'b1;
        exp_d[i][edge_n+LAT] = win_sum();
      end
    end
    n_acc++;
    fpos++;
  endtask

  task automatic tick(input logic rst, input logic v, input logic s, input logic [15:0] px);
    logic [63:0] got;
    logic        gv;
    @(negedge clock);
    reset = ~rst; pixel_valid_in = v; pixel_sof_in = s; pixel_vector_in = px;
    @(posedge clock);
    edge_n++;
    if (rst) begin
      for (int e = edge_n; e <= edge_n + LAT; e++) begin exp_v[0][e] = 1'b0; exp_v[1][e] = 1'b0; end
      last_d[0] = 64'd0; last_d[1] = 64'd0; fpos = 0;
    end else if (v) begin
      model_accept(s, px);
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? out0 : out1;
      gv  = (i == 0) ? vld0 : vld1;
      check_eq($sformatf("valid s%0d e%0d", i+1, edge_n), 64'(gv), 64'(exp_v[i][edge_n]));
      if (exp_v[i][edge_n]) begin
        check_eq($sformatf("data s%0d e%0d", i+1, edge_n), got, exp_d[i][edge_n]);
        last_d[i] = exp_d[i][edge_n];
      end else begin
        check_eq($sformatf("hold s%0d e%0d", i+1, edge_n), got, last_d[i]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  function automatic logic [15:0] cnt_px(input int p);
    logic [7:0] b;
    b = 8'(p);
    return {b, b};
  endfunction

  initial begin
    reset = 1'b0; pixel_valid_in = 1'b0; pixel_sof_in = 1'b0; pixel_vector_in = '0;
    last_d[0] = '0; last_d[1] = '0;
    for (int t = 0; t < T; t++)
      for (int z = 0; z < Z; z++)
        for (int p = 0; p < KK; p++) kernel[8*((z*T+t)*KK+p) +: 8] = (t == 0) ? 8'h01 : 8'hFF;

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 16'h0);

    // Basic frame, continued past four rows for the stride-2 row-3 result.
    for (int p = 0; p < 24; p++) begin
      tick(1'b0, 1'b1, p == 0, cnt_px(p));
      if (p == 10) begin
        check_eq("plan s1 first", out0, with_bias(32'hFFFFFFEC, 32'd20));
        check_eq("plan s2 first", out1, with_bias(32'hFFFFFFEC, 32'd20));
      end
      if (p == 11) check_eq("plan s1 second", out0, with_bias(32'hFFFFFFE4, 32'd28));
      if (p == 12) check_eq("plan s2 col3", out1, with_bias(32'hFFFFFFDC, 32'd36));
      if (p == 18) check_eq("plan s2 row3", out1, with_bias(32'hFFFFFFAC, 32'd84));
    end
    idle(6);

    // Input gap after pixel 5.
    for (int p = 0; p < 12; p++) begin
      tick(1'b0, 1'b1, p == 0, cnt_px(p));
      if (p == 5) idle(3);
    end
    idle(6);

    // Reset while pixel 6's result is in flight, then restart.
    for (int p = 0; p < 8; p++) tick(1'b0, 1'b1, p == 0, cnt_px(p));
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 16'h0);
    for (int p = 0; p < 11; p++) begin
      tick(1'b0, 1'b1, p == 0, cnt_px(p));
      if (p == 10) begin
        check_eq("plan restart valid", 64'(vld0), 64'd1);
        check_eq("plan restart data", out0, with_bias(32'hFFFFFFEC, 32'd20));
      end
    end
    idle(6);

    // Mid-frame sof on pixel 10.
    for (int p = 0; p < 22; p++) tick(1'b0, 1'b1, p == 0 || p == 10, cnt_px(p));
    idle(6);

    // Randomised traffic; kernel only changes once the pipeline has drained.
    for (int blk = 0; blk < 5; blk++) begin
      for (int b = 0; b < 8*T*KK*Z; b += 32) kernel[b +: 32] = $urandom;
      tick(1'b0, 1'b1, 1'b1, 16'($urandom));
      for (int i = 0; i < 300; i++)
        tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 29) == 0, 16'($urandom));
      idle(6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
